// File: rtl/xy2_100_tx.sv
`default_nettype none
// xy2_100_tx -- XY2-100 controller-side transmitter: serialises X/Y set-points
// into continuous 20-bit frames (3 control bits, 16 data bits, even parity).
module xy2_100_tx #(
  parameter int unsigned HALF_PERIOD = 5,
  parameter logic [2:0]  CTRL_BITS   = 3'b001
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  input  logic        en,
  input  logic [15:0] pos_x,
  input  logic [15:0] pos_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic        frame_start,
  output logic        xy_clk,
  output logic        xy_sync,
  output logic        xy_x,
  output logic        xy_y,
  input  logic        xy_status,
  output logic        status_sync
);

  localparam int unsigned      DIV_W    = $clog2(2 * HALF_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(HALF_PERIOD - 1);
  localparam logic [4:0]       BIT_LAST = 5'd19;
  localparam logic [4:0]       BIT_PRTY = 5'd18;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [4:0]       bit_cnt_q;
  logic [18:0]      sr_x_q, sr_y_q;
  logic             xy_clk_q, xy_sync_q, xy_x_q, xy_y_q, frame_start_q;
  logic [15:0]      cur_x_q, cur_y_q, cur_x_d, cur_y_d;
  logic [15:0]      hold_x_q, hold_y_q, hold_x_d, hold_y_d;
  logic             hold_full_q, hold_full_d;
  logic             sync1_q, sync2_q;
  logic             w_load, w_accept;
  logic [19:0]      w_frame_x, w_frame_y;

  function automatic logic [19:0] make_frame(input logic [15:0] d);
    logic [18:0] b;
    b = {CTRL_BITS, d};
    return {b, ^b};
  endfunction

  assign w_load = en && ((state_q == S_IDLE) ||
                         (div_cnt_q == DIV_LAST && bit_cnt_q == BIT_LAST));
  assign w_accept = pos_valid && !hold_full_q;

  // A load in the same cycle as an accept consumes the old holding state,
  // so the freshly accepted pair waits for the following frame.
  always_comb begin
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    hold_x_d    = hold_x_q;
    hold_y_d    = hold_y_q;
    hold_full_d = hold_full_q;
    if (w_load && hold_full_q) begin
      cur_x_d     = hold_x_q;
      cur_y_d     = hold_y_q;
      hold_full_d = 1'b0;
    end
    if (w_accept) begin
      hold_x_d    = pos_x;
      hold_y_d    = pos_y;
      hold_full_d = 1'b1;
    end
  end

  assign w_frame_x = make_frame(cur_x_d);
  assign w_frame_y = make_frame(cur_y_d);

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cur_x_q     <= 16'h0000;
      cur_y_q     <= 16'h0000;
      hold_x_q    <= 16'h0000;
      hold_y_q    <= 16'h0000;
      hold_full_q <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      hold_x_q    <= hold_x_d;
      hold_y_q    <= hold_y_d;
      hold_full_q <= hold_full_d;
      sync1_q     <= xy_status;
      sync2_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      bit_cnt_q     <= 5'd0;
      sr_x_q        <= 19'd0;
      sr_y_q        <= 19'd0;
      xy_clk_q      <= 1'b0;
      xy_sync_q     <= 1'b0;
      xy_x_q        <= 1'b0;
      xy_y_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (w_load) begin
        state_q       <= S_SEND;
        div_cnt_q     <= '0;
        bit_cnt_q     <= 5'd0;
        xy_clk_q      <= 1'b1;
        xy_sync_q     <= 1'b1;
        xy_x_q        <= w_frame_x[19];
        xy_y_q        <= w_frame_y[19];
        sr_x_q        <= w_frame_x[18:0];
        sr_y_q        <= w_frame_y[18:0];
        frame_start_q <= 1'b1;
      end else if (state_q == S_SEND) begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_q <= '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 5'd0;
            xy_clk_q  <= 1'b0;
            xy_sync_q <= 1'b0;
            xy_x_q    <= 1'b0;
            xy_y_q    <= 1'b0;
            sr_x_q    <= 19'd0;
            sr_y_q    <= 19'd0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            xy_clk_q  <= 1'b1;
            xy_sync_q <= (bit_cnt_q != BIT_PRTY);
            xy_x_q    <= sr_x_q[18];
            xy_y_q    <= sr_y_q[18];
            sr_x_q    <= {sr_x_q[17:0], 1'b0};
            sr_y_q    <= {sr_y_q[17:0], 1'b0};
          end
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == DIV_FALL) xy_clk_q <= 1'b0;
        end
      end
    end
  end

  assign pos_ready   = !hold_full_q;
  assign frame_start = frame_start_q;
  assign xy_clk      = xy_clk_q;
  assign xy_sync     = xy_sync_q;
  assign xy_x        = xy_x_q;
  assign xy_y        = xy_y_q;
  assign status_sync = sync2_q;

endmodule
`default_nettype wire

// File: tb/tb_xy2_100_tx.sv
`default_nettype none
// tb_xy2_100_tx -- scoreboard bench: stimulus queues expected frames, a monitor
// deserialises xy_x/xy_y on falling xy_clk and compares.
module tb_xy2_100_tx;

  localparam int HP        = 5;
  localparam int FRAME_CYC = 200;

  // Hand-computed frames: ctrl 001, data MSB first, even parity
  localparam logic [19:0] FZ   = 20'b001_0000000000000000_1; // 0x0000
  localparam logic [19:0] FPX  = 20'b001_1000000000000001_1; // 0x8001
  localparam logic [19:0] FPY  = 20'b001_0001001000110100_0; // 0x1234
  localparam logic [19:0] FAX  = 20'b001_1111111111111111_1; // 0xFFFF
  localparam logic [19:0] FAY  = 20'b001_0000000000000011_1; // 0x0003
  localparam logic [19:0] FBX  = 20'b001_0000000011110000_1; // 0x00F0
  localparam logic [19:0] FBY  = 20'b001_1010010110100100_0; // 0xA5A4
  localparam logic [19:0] FCX  = 20'b001_0111111111111110_1; // 0x7FFE
  localparam logic [19:0] FCY  = 20'b001_0000000100000000_0; // 0x0100

  logic        clk_ref = 1'b0;
  logic        sys_rstn, en, pos_valid, xy_status;
  logic [15:0] pos_x, pos_y;
  logic        pos_ready, frame_start, xy_clk, xy_sync, xy_x, xy_y, status_sync;

  typedef struct packed {
    logic [19:0] fx;
    logic [19:0] fy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_ref = ~clk_ref;

  xy2_100_tx #(.HALF_PERIOD(HP), .CTRL_BITS(3'b001)) dut (
    .clk_ref     (clk_ref),
    .sys_rstn    (sys_rstn),
    .en          (en),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .frame_start (frame_start),
    .xy_clk      (xy_clk),
    .xy_sync     (xy_sync),
    .xy_x        (xy_x),
    .xy_y        (xy_y),
    .xy_status   (xy_status),
    .status_sync (status_sync)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int          nbits, cyc, last_fs, low_run;
    bit          in_frame, have_prev, gap;
    logic        prev_clk;
    logic [19:0] sh_x, sh_y, sh_s;
    exp_t        e;
    nbits = 0; cyc = 0; last_fs = 0; low_run = 0;
    in_frame = 0; have_prev = 0; gap = 0; prev_clk = 1'b0;
    sh_x = '0; sh_y = '0; sh_s = '0;
    forever begin
      @(negedge clk_ref);
      if (!sys_rstn) begin
        nbits = 0; in_frame = 0; have_prev = 0; gap = 0; low_run = 0; prev_clk = 1'b0;
      end else begin
        cyc++;
        if (frame_start) begin
          if (have_prev && !gap) check("frame_period", cyc - last_fs, FRAME_CYC);
          if (in_frame) check("frame_truncated_bits", nbits, 20);
          have_prev = 1; last_fs = cyc; gap = 0; in_frame = 1; nbits = 0;
        end
        if (!xy_clk && !xy_sync) begin
          low_run++;
          if (low_run > HP) gap = 1;
        end else begin
          low_run = 0;
        end
        if (in_frame && prev_clk && !xy_clk) begin
          sh_x = {sh_x[18:0], xy_x};
          sh_y = {sh_y[18:0], xy_y};
          sh_s = {sh_s[18:0], xy_sync};
          nbits++;
          if (nbits == 20) begin
            in_frame = 0;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("frame_x", {12'h0, sh_x}, {12'h0, e.fx});
              check("frame_y", {12'h0, sh_y}, {12'h0, e.fy});
              check("frame_sync", {12'h0, sh_s}, 32'h000F_FFFE);
            end
          end
        end
        prev_clk = xy_clk;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ref);
      #1;
    end
  endtask

  task automatic wait_fs(input string tag);
    bit found;
    found = 0;
    for (int k = 0; k < 450 && !found; k++) begin
      tick(1);
      if (frame_start) found = 1;
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic offer(input logic [15:0] x, input logic [15:0] y,
                       output bit fs_at_acc, output int stalls);
    bit done;
    done = 0; stalls = 0; fs_at_acc = 0;
    pos_x = x; pos_y = y; pos_valid = 1'b1;
    for (int k = 0; k < 450 && !done; k++) begin
      if (pos_ready) begin
        fs_at_acc = frame_start;
        done = 1;
      end else begin
        stalls++;
      end
      tick(1);
    end
    pos_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic push(input logic [19:0] fx, input logic [19:0] fy);
    exp_t e;
    e.fx = fx;
    e.fy = fy;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit fs_acc;
    int stalls;
    sys_rstn = 1'b0; en = 1'b0; pos_valid = 1'b0; xy_status = 1'b0;
    pos_x = '0; pos_y = '0;
    tick(3);
    check("reset_lines", {27'd0, xy_clk, xy_sync, xy_x, xy_y, frame_start}, 0);
    check("reset_ready", pos_ready, 1);
    check("reset_status", status_sync, 0);
    sys_rstn = 1'b1;
    tick(5);
    check("idle_no_en", {27'd0, xy_clk, xy_sync, xy_x, xy_y, frame_start}, 0);

    // start-up, then reset mid-frame with a pair sitting in the holding register
    en = 1'b1;
    tick(1);
    check("startup_lines", {29'd0, frame_start, xy_clk, xy_sync}, 32'h7);
    offer(16'hFFFF, 16'h0003, fs_acc, stalls);
    tick(60);
    check("preload_hold_full", pos_ready, 0);
    #2 sys_rstn = 1'b0;
    #1;
    check("async_reset_lines", {27'd0, xy_clk, xy_sync, xy_x, xy_y, frame_start}, 0);
    check("async_reset_ready", pos_ready, 1);
    push(FZ, FZ);
    push(FZ, FZ);
    @(posedge clk_ref);
    @(posedge clk_ref);
    #1 sys_rstn = 1'b1;
    tick(1);
    check("restart_frame_start", {30'd0, frame_start, xy_clk}, 32'h3);

    // single frame plus three repeats
    wait_fs("z2");
    tick(5);
    for (int i = 0; i < 4; i++) push(FPX, FPY);
    offer(16'h8001, 16'h1234, fs_acc, stalls);
    check("p_no_stall", stalls, 0);
    for (int i = 0; i < 4; i++) wait_fs("p");

    // backpressure: A then B back to back
    tick(10);
    push(FAX, FAY);
    push(FBX, FBY);
    offer(16'hFFFF, 16'h0003, fs_acc, stalls);
    check("a_no_stall", stalls, 0);
    check("b_stalled_ready", pos_ready, 0);
    offer(16'h00F0, 16'hA5A4, fs_acc, stalls);
    check("b_accept_at_a_load", fs_acc, 1);
    check("b_stalled_some", stalls > 100, 1);

    // accept in the exact load cycle: deferred one frame
    wait_fs("b");
    tick(199);
    check("c_ready_before", pos_ready, 1);
    push(FBX, FBY);
    push(FCX, FCY);
    pos_x = 16'h7FFE; pos_y = 16'h0100; pos_valid = 1'b1;
    tick(1);
    pos_valid = 1'b0;
    check("c_load_cycle", frame_start, 1);
    check("c_held", pos_ready, 0);

    // enable drop at bit 7 of C's frame
    wait_fs("c");
    tick(72);
    en = 1'b0;
    tick(127);
    check("bit19_still_sent", {30'd0, xy_clk, xy_sync}, 0);
    tick(1);
    check("idle_after_drop", {27'd0, xy_clk, xy_sync, xy_x, xy_y, frame_start}, 0);
    tick(10);
    check("idle_stays", {27'd0, xy_clk, xy_sync, xy_x, xy_y, frame_start}, 0);
    push(FCX, FCY);
    en = 1'b1;
    tick(1);
    check("reenable_start", {30'd0, frame_start, xy_clk}, 32'h3);

    // status synchroniser
    xy_status = 1'b1;
    tick(1);
    check("status_rise_1", status_sync, 0);
    tick(1);
    check("status_rise_2", status_sync, 1);
    xy_status = 1'b0;
    tick(1);
    check("status_fall_1", status_sync, 1);
    tick(1);
    check("status_fall_2", status_sync, 0);

    en = 1'b0;
    tick(220);
    check("frames_pending", exp_q.size(), 0);
    check("final_idle", {27'd0, xy_clk, xy_sync, xy_x, xy_y, frame_start}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
